// File: rtl/boid_pkg.sv
// boid_pkg: boid record layout, field widths, FSM states and unpack helpers
package boid_pkg;
  localparam int X_W = 28;
  localparam int Y_W = 27;
  localparam int V_W = 21;
  localparam int FRAC_W = 16;
  localparam int REC_W = 97;
  localparam int WORD_W = 32;
  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [V_W-1:0] vx;
    logic [V_W-1:0] vy;
  } boid_rec_t;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} fetch_state_t;
  function automatic logic [WORD_W-1:0] unpack_x(input logic [X_W-1:0] v);
    return {{(WORD_W-X_W){1'b0}}, v};
  endfunction
  function automatic logic [WORD_W-1:0] unpack_y(input logic [Y_W-1:0] v);
    return {{(WORD_W-Y_W){1'b0}}, v};
  endfunction
  function automatic logic [WORD_W-1:0] unpack_v(input logic [V_W-1:0] v);
    return {{(WORD_W-V_W){v[V_W-1]}}, v};
  endfunction
endpackage

// File: rtl/boid_skid_fifo.sv
// boid_skid_fifo: 2-entry output FIFO with head-of-queue view
module boid_skid_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [1:0]   occ,
  output logic [W-1:0] head
);
  logic [W-1:0] e0, e1;
  assign head = e0;
  always_ff @(posedge clk) begin
    if (reset) begin
      e0 <= '0;
      e1 <= '0;
      occ <= '0;
    end else begin
      occ <= occ + {1'b0, push} - {1'b0, pop};
      if (pop && occ == 2'd2)
        e0 <= e1;
      if (push) begin
        if (occ == 2'd0 || (occ == 2'd1 && pop))
          e0 <= din;
        else
          e1 <= din;
      end
    end
  end
endmodule

// File: rtl/boid_fetch.sv
// boid_fetch: streams unpacked boid records from M10K in index order; BOID_FETCH_SKIP_SELF_EN skips self_idx
module boid_fetch
  import boid_pkg::*;
#(
  parameter int NUM_BOIDS = 32,
  localparam int IDX_W = (NUM_BOIDS > 1) ? $clog2(NUM_BOIDS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [IDX_W-1:0]   self_idx,
  output logic               busy,
  output logic               done,
  output logic               mem_rd_en,
  output logic [IDX_W-1:0]   mem_rd_addr,
  input  logic [REC_W-1:0]   mem_rd_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD_W-1:0]  out_x,
  output logic [WORD_W-1:0]  out_y,
  output logic [WORD_W-1:0]  out_vx,
  output logic [WORD_W-1:0]  out_vy,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_last
);
`ifdef BOID_FETCH_SKIP_SELF_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] NB = PTR_W'(NUM_BOIDS);
  typedef struct packed {
    logic             last;
    logic [IDX_W-1:0] idx;
    boid_rec_t        rec;
  } ent_t;
  fetch_state_t     state;
  logic [PTR_W-1:0] ptr, nxt_raw, nxt;
  logic [IDX_W-1:0] self_q, infl_idx;
  logic             inflight, infl_last, pop, has_addr, issue, last, finish;
  logic [1:0]       occ;
  ent_t             head;
  assign pop = out_valid & out_ready;
  assign has_addr = ptr < NB;
  assign issue = state == STREAM && has_addr && ({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});
  assign nxt_raw = ptr + PTR_W'(1);
  assign nxt = (SKIP && nxt_raw == {1'b0, self_q}) ? ptr + PTR_W'(2) : nxt_raw;
  assign last = nxt >= NB;
  assign finish = !inflight && occ == {1'b0, pop};
  assign busy = state != IDLE;
  assign mem_rd_en = issue;
  assign mem_rd_addr = ptr[IDX_W-1:0];
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      self_q <= '0;
      inflight <= 1'b0;
      infl_idx <= '0;
      infl_last <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      inflight <= issue;
      infl_idx <= ptr[IDX_W-1:0];
      infl_last <= last;
      if (state == IDLE) begin
        if (start) begin
          self_q <= self_idx;
          ptr <= (SKIP && self_idx == '0) ? PTR_W'(1) : '0;
          state <= STREAM;
        end
      end else if (state == STREAM) begin
        if (!has_addr) begin
          state <= IDLE;
          done <= 1'b1;
        end else if (issue) begin
          ptr <= nxt;
          if (last)
            state <= DRAIN;
        end
      end else if (finish) begin
        state <= IDLE;
        done <= 1'b1;
      end
    end
  end
  boid_skid_fifo #(.W($bits(ent_t))) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inflight),
    .pop   (pop),
    .din   ({infl_last, infl_idx, mem_rd_data}),
    .occ   (occ),
    .head  (head)
  );
  assign out_valid = occ != 2'd0;
  assign out_last = out_valid & head.last;
  assign out_idx = head.idx;
  assign out_x = unpack_x(head.rec.x);
  assign out_y = unpack_y(head.rec.y);
  assign out_vx = unpack_v(head.rec.vx);
  assign out_vy = unpack_v(head.rec.vy);
endmodule

// File: tb/tb_boid_fetch.sv
// tb_boid_fetch: scoreboard bench for boid_fetch (NUM_BOIDS=8 main instance, NUM_BOIDS=1 edge instance)
module tb_boid_fetch;
  import boid_pkg::*;
  localparam int N = 8;
  localparam int IW = 3;
`ifdef BOID_FETCH_SKIP_SELF_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  typedef struct {
    int          idx;
    bit          last;
    logic [31:0] x, y, vx, vy;
    int          ecyc;
  } exp_t;
  logic clk = 0, reset = 1, start = 0, ready = 1;
  logic [IW-1:0] self_idx = '0;
  logic busy, done, rd_en, valid, last;
  logic [IW-1:0] rd_addr, idx;
  logic [96:0] rd_data;
  logic [31:0] ox, oy, ovx, ovy;
  logic e_start = 0, e_ready = 1;
  logic [0:0] e_self = '0;
  logic e_busy, e_done, e_rd_en, e_valid, e_last;
  logic [0:0] e_rd_addr, e_idx;
  logic [96:0] e_rd_data;
  logic [31:0] e_x, e_y, e_vx, e_vy;
  boid_rec_t mem [N];
  exp_t q[$];
  exp_t e;
  int nchk = 0, nerr = 0, cyc = 0, c0 = 0, nhs = 0, cnt = 0;
  bit stall = 0;
  logic [131:0] snap;

  boid_fetch #(.NUM_BOIDS(N)) u_dut (
    .clk(clk), .reset(reset), .start(start), .self_idx(self_idx), .busy(busy), .done(done),
    .mem_rd_en(rd_en), .mem_rd_addr(rd_addr), .mem_rd_data(rd_data), .out_valid(valid),
    .out_ready(ready), .out_x(ox), .out_y(oy), .out_vx(ovx), .out_vy(ovy), .out_idx(idx), .out_last(last)
  );
  boid_fetch #(.NUM_BOIDS(1)) u_one (
    .clk(clk), .reset(reset), .start(e_start), .self_idx(e_self), .busy(e_busy), .done(e_done),
    .mem_rd_en(e_rd_en), .mem_rd_addr(e_rd_addr), .mem_rd_data(e_rd_data), .out_valid(e_valid),
    .out_ready(e_ready), .out_x(e_x), .out_y(e_y), .out_vx(e_vx), .out_vy(e_vy), .out_idx(e_idx), .out_last(e_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rd_data <= rd_en ? 97'(mem[rd_addr]) : 97'({$urandom, $urandom, $urandom, $urandom});
  always @(posedge clk) e_rd_data <= e_rd_en ? 97'(mem[0]) : 97'({$urandom, $urandom, $urandom, $urandom});

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] zx(input logic [27:0] v);
    return {4'h0, v};
  endfunction

  task automatic push_exp(input int self, input bit tm, output int ne);
    int li = -1;
    ne = 0;
    for (int i = 0; i < N; i++) if (!(SKIP && i == self)) li = i;
    for (int i = 0; i < N; i++) if (!(SKIP && i == self)) begin
      exp_t x;
      x.idx = i;
      x.last = (i == li);
      x.x = zx(mem[i].x);
      x.y = {5'h0, mem[i].y};
      x.vx = {{11{mem[i].vx[20]}}, mem[i].vx};
      x.vy = {{11{mem[i].vy[20]}}, mem[i].vy};
      x.ecyc = tm ? 3 + ne : 0;
      q.push_back(x);
      ne++;
    end
  endtask

  task automatic run_sweep(input int self, input bit alt, input bit tm, input bit mid);
    int ne, k = 0;
    push_exp(self, tm, ne);
    self_idx = IW'(self);
    start = 1;
    ready = 1;
    c0 = cyc;
    @(posedge clk); #1;
    start = 0;
    if (tm) chk("c1_rd", {rd_en, rd_addr}, {1'b1, IW'((SKIP && self == 0) ? 1 : 0)});
    while (!done && k < 300) begin
      ready = alt ? ~ready : 1'b1;
      start = mid && k == 4;
      @(posedge clk); #1;
      k++;
    end
    start = 0;
    chk("done_seen", done, 1);
    if (tm) chk("done_cyc", cyc - c0, 3 + ne);
    chk("q_empty", q.size(), 0);
    chk("busy_at_done", busy, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk(tag, {busy, done, rd_en, rd_addr, valid, last, idx, ox, oy, ovx, ovy}, '0);
  endtask

  initial forever begin
    @(negedge clk);
    if (reset) begin
      q.delete();
      cnt = 0;
      stall = 0;
    end else begin
      if (stall) chk("hold", {valid, idx, ox, oy, ovx, ovy}, snap);
      stall = valid && !ready;
      snap = {valid, idx, ox, oy, ovx, ovy};
      if (rd_en) chk("rd_rule", (cnt - int'(valid && ready)) < 2, 1);
      cnt += int'(rd_en) - int'(valid && ready);
      if (valid && ready) begin
        nhs++;
        if (q.size() == 0) chk("extra_out", {1'b1, idx}, 0);
        else begin
          e = q.pop_front();
          chk("idx", idx, e.idx);
          chk("last", last, e.last);
          chk("data", {ox, oy, ovx, ovy}, {e.x, e.y, e.vx, e.vy});
          if (e.ecyc > 0) chk("out_cyc", cyc - c0, e.ecyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int h0, ne, k;
    for (int i = 0; i < N; i++)
      mem[i] = boid_rec_t'({28'($urandom), 27'($urandom), 21'($urandom), 21'($urandom)});
    mem[1] = '{x: 28'h0960000, y: 27'h0960000, vx: 21'h1D0000, vy: 21'h030000};
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    chk_reset_vals("reset_vals");
    run_sweep(2, 0, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    h0 = nhs;
    run_sweep(5, 1, 0, 0);
    chk("alt_hs", nhs - h0, SKIP ? N - 1 : N);
    repeat (2) @(posedge clk);
    #1;
    run_sweep(3, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    run_sweep(N - 1, 0, 1, 0);
    run_sweep(0, 0, 1, 0);
    repeat (4) @(posedge clk);
    #1;
    h0 = nhs;
    push_exp(4, 0, ne);
    self_idx = IW'(4);
    start = 1;
    ready = 1;
    @(posedge clk); #1;
    start = 0;
    k = 0;
    while (nhs - h0 < 2 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("pre_reset_hs", nhs - h0 >= 2, 1);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk_reset_vals("midreset_vals");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("stale_drop", {valid, busy}, 0);
    end
    run_sweep(1, 0, 1, 0);
    repeat (2) @(posedge clk);
    #1;
    e_start = 1;
    @(posedge clk); #1;
    e_start = 0;
    for (int n = 1; n <= 5; n++) begin
      chk("one_done", e_done, n == (SKIP ? 2 : 4));
      chk("one_valid", e_valid, !SKIP && n == 3);
      if (n == 3) chk("one_rec", {e_idx, e_last, e_x, e_vy}, SKIP ? '0 : {1'b0, 1'b1, zx(mem[0].x), {{11{mem[0].vy[20]}}, mem[0].vy}});
      @(posedge clk); #1;
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/boid_fetch.md
# boid_fetch

Read-side streamer for the boid state memory. On a start pulse it sweeps the M10K boid array in index order and reads each packed 97-bit boid record. It unpacks each record into 32-bit fixed-point words with 16 fractional bits and streams them over a valid/ready interface into the neighbour-accumulation datapath (xy_sep_chk). It is the reader counterpart to the writeback path that packs updated state into the same memory.

## Interface
- NUM_BOIDS, default 32: number of records in memory, 1..64.
- IDX_W, derived localparam, $clog2(NUM_BOIDS) with a minimum of 1: index width.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  sweep request; sampled only when busy=0.
- self_idx  in  IDX_W  focal boid index; latched on an accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at the end of a sweep.
- mem_rd_en  out  1  M10K read strobe.
- mem_rd_addr  out  IDX_W  M10K read address.
- mem_rd_data  in  97  record {x[27:0], y[26:0], vx[20:0], vy[20:0]}, valid the cycle after mem_rd_en.
- out_valid  out  1  output record valid.
- out_ready  in  1  consumer accept.
- out_x, out_y, out_vx, out_vy  out  32  unpacked state.
- out_idx  out  IDX_W  record index.
- out_last  out  1  final record of the sweep.

## Operation
- FSM states:
  - IDLE: an accepted start latches self_idx, sets rd_ptr=0 and goes to STREAM.
  - STREAM: issues reads.
  - DRAIN: all reads issued; waits until the FIFO is empty and no read is in flight, then asserts done and returns to IDLE.
- Read issue rule: issue when occ + inflight − pop < 2.
  - pop = out_valid & out_ready.
  - On each issue, rd_ptr increments.
  - Going to DRAIN happens after the read of the final address is issued.
- In-flight flag: a 1-bit register. mem_rd_data is captured into the FIFO only when this flag is set.
- Output buffer: a 2-entry FIFO.
  - The head drives all out_* signals.
  - Head data holds stable while out_valid=1 and out_ready=0.
- Unpack rules:
  - out_x = zero-extend of x (28→32).
  - out_y = zero-extend of y (27→32).
  - out_vx and out_vy = sign-extend (21→32).
  - No rounding; fraction bits are preserved.
- out_last: set on the record whose index is the final issued address.
- start while busy=1 is ignored. start in the done cycle is accepted, because the FSM is already in IDLE.
- Reset, including mid-sweep: the FSM goes to IDLE, the FIFO is emptied and the in-flight flag is cleared. Any stale mem_rd_data is dropped.
- Reset values: busy 0, done 0, mem_rd_en 0, mem_rd_addr 0, out_valid 0, out_last 0, and all out_* data and out_idx 0.

## Timing
- start high in cycle C0 → mem_rd_en=1 with addr 0 in C1 → mem_rd_data in C2 → out_valid in C3.
- Sustained throughput: 1 record per cycle while out_ready=1.
- done: pulses in the cycle after the handshake of the out_last record; busy drops in that same cycle.
- Empty sweep: done pulses in C2 with no out_valid. Only possible when skip-self is enabled and NUM_BOIDS=1.
- mem_rd_en is never high when the FIFO has 2 entries and nothing is being popped.

## Configuration
- BOID_FETCH_SKIP_SELF_EN
  - Defined: the address sequence skips self_idx, so NUM_BOIDS−1 records are emitted, and out_last is on the highest non-self index.
  - Undefined: all NUM_BOIDS records are emitted, self included, and self_idx is ignored.

## Structure
- boid_pkg holds:
  - X_W=28, Y_W=27, V_W=21, FRAC_W=16, REC_W=97.
  - boid_rec_t, a packed struct of the four fields.
  - Unpack functions producing 32-bit words.
- Shared with the writeback and memory-wrapper modules.
- Sub-module: boid_skid_fifo, a 2-entry FIFO with push/pop, occ and head outputs, and reset.

## Test plan
- NUM_BOIDS=4, self_idx=2, out_ready=1, macro undefined → idx 0,1,2,3 in C3..C6, out_last with idx 3, done in C7. Macro defined → idx 0,1,3, with out_last on 3.
- Record with x=28'h0960000, y=27'h0960000, vx=21'h1D0000, vy=21'h030000 → out_x=32'h00960000, out_y=32'h00960000, out_vx=32'hFFFD0000, out_vy=32'h00030000.
- out_ready alternating 1/0 over NUM_BOIDS=8 → exactly 8 handshakes with idx 0..7, no duplicates. Data is held stable while stalled, and mem_rd_en=0 whenever occ=2 and there is no pop.
- reset pulsed after 2 handshakes of 8 → next cycle every output is at its reset value, and the stale read is not emitted. A later start replays from idx 0.
- start re-pulsed mid-sweep → ignored, sequence unchanged. start in the done cycle → new sweep, with mem_rd_en in the next cycle.
- NUM_BOIDS=1, self_idx=0, macro defined → done in C2, out_valid never asserted.
